// File: rtl/ahb_matrix_decode_multi.sv
// AHB matrix input-stage decoder: mask/base decode onto NUM_PORTS output ports plus an
// integrated default slave, with a data-phase response mux and an unmapped-access log.
module ahb_matrix_decode_multi #(
   parameter int                      NUM_PORTS = 4,
   parameter logic [NUM_PORTS*22-1:0] PORT_BASE = {(NUM_PORTS*22){1'b0}},
   parameter logic [NUM_PORTS*22-1:0] PORT_MASK = {(NUM_PORTS*22){1'b1}},
   parameter int                      CNT_W     = 8,
   parameter bit                      IDLE_HOLD = 1'b1
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      HREADYS,
   input  logic                      sel_dec,
   input  logic [21:0]               decode_addr_dec,
   input  logic [1:0]                trans_dec,
   input  logic [NUM_PORTS-1:0]      active_in,
   input  logic [NUM_PORTS-1:0]      readyout_in,
   input  logic [2*NUM_PORTS-1:0]    resp_in,
   input  logic [32*NUM_PORTS-1:0]   rdata_in,
   input  logic [32*NUM_PORTS-1:0]   ruser_in,
   input  logic                      dft_err_clr,
   output logic [NUM_PORTS-1:0]      sel_out,
   output logic                      active_dec,
   output logic                      HREADYOUTS,
   output logic [1:0]                HRESPS,
   output logic [31:0]               HRDATAS,
   output logic [31:0]               HRUSERS,
   output logic [CNT_W-1:0]          dft_err_count,
   output logic [21:0]               dft_err_addr,
   output logic [1:0]                o_dft_state
);

   // Handshake: an address phase is accepted on a rising HCLK edge with HREADYS=1; the
   // data phase it opens completes on the first later edge where HREADYOUTS=1.
   localparam int             PW      = $clog2(NUM_PORTS + 1);
   localparam logic [PW-1:0]  DFT_IDX = PW'(NUM_PORTS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ERR1 = 2'd1,
      S_ERR2 = 2'd2
   } dft_state_t;

   dft_state_t         r_state;
   logic               r_dft_ready;
   logic [1:0]         r_dft_resp;
   logic [PW-1:0]      r_data_port;
   logic [CNT_W-1:0]   r_err_count;
   logic [21:0]        r_err_addr;

   logic [PW-1:0]          w_dec_port;
   logic [PW-1:0]          w_addr_port;
   logic                   w_hold;
   logic                   w_dft_sel;
   logic                   w_err_evt;
   logic [NUM_PORTS-1:0]   w_sel;
   logic                   w_active;
   logic                   w_ready;
   logic [1:0]             w_resp;
   logic [31:0]            w_rdata;
   logic [31:0]            w_ruser;

   // Scan from the top so the lowest-indexed hitting port is the last assignment.
   always_comb begin
      w_dec_port = DFT_IDX;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if ((decode_addr_dec & PORT_MASK[22*i +: 22]) ==
             (PORT_BASE[22*i +: 22] & PORT_MASK[22*i +: 22]))
            w_dec_port = PW'(i);
      end
   end

   assign w_hold      = IDLE_HOLD && (trans_dec == 2'b00) && (r_data_port < DFT_IDX);
   assign w_addr_port = w_hold ? r_data_port : w_dec_port;

   always_comb begin
      w_sel    = '0;
      w_active = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (w_addr_port == PW'(i)) begin
            w_sel[i] = sel_dec;
            w_active = active_in[i];
         end
      end
   end

   assign w_dft_sel = sel_dec & (w_addr_port == DFT_IDX);
   assign w_err_evt = w_dft_sel & HREADYS & trans_dec[1];

   always_comb begin
      w_ready = r_dft_ready;
      w_resp  = r_dft_resp;
      w_rdata = '0;
      w_ruser = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (r_data_port == PW'(i)) begin
            w_ready = readyout_in[i];
            w_resp  = resp_in[2*i +: 2];
            w_rdata = rdata_in[32*i +: 32];
            w_ruser = ruser_in[32*i +: 32];
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         r_data_port <= DFT_IDX;
      else if (HREADYS)
         r_data_port <= w_addr_port;
   end

   // Default slave: two-cycle ERROR response, outputs registered with the state.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= S_IDLE;
         r_dft_ready <= 1'b1;
         r_dft_resp  <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_err_evt) begin
                  r_state     <= S_ERR1;
                  r_dft_ready <= 1'b0;
                  r_dft_resp  <= 2'b01;
               end
            end
            S_ERR1: begin
               r_state     <= S_ERR2;
               r_dft_ready <= 1'b1;
               r_dft_resp  <= 2'b01;
            end
            S_ERR2: begin
               if (w_err_evt) begin
                  r_state     <= S_ERR1;
                  r_dft_ready <= 1'b0;
                  r_dft_resp  <= 2'b01;
               end else begin
                  r_state     <= S_IDLE;
                  r_dft_ready <= 1'b1;
                  r_dft_resp  <= 2'b00;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_dft_ready <= 1'b1;
               r_dft_resp  <= 2'b00;
            end
         endcase
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_err_count <= '0;
         r_err_addr  <= '0;
      end else if (dft_err_clr) begin
         r_err_count <= w_err_evt ? CNT_W'(1) : '0;
         r_err_addr  <= w_err_evt ? decode_addr_dec : '0;
      end else if (w_err_evt) begin
         r_err_addr <= decode_addr_dec;
         if (r_err_count != {CNT_W{1'b1}})
            r_err_count <= r_err_count + 1'b1;
      end
   end

   assign sel_out       = w_sel;
   assign active_dec    = w_active;
   assign HREADYOUTS    = w_ready;
   assign HRESPS        = w_resp;
   assign HRDATAS       = w_rdata;
   assign HRUSERS       = w_ruser;
   assign dft_err_count = r_err_count;
   assign dft_err_addr  = r_err_addr;
   assign o_dft_state   = r_state;

endmodule

// File: tb/tb_ahb_matrix_decode_multi.sv
// Directed bench for ahb_matrix_decode_multi: two instances (IDLE hold on / off) share
// stimulus; expected values are hand-computed constants.
module tb_ahb_matrix_decode_multi;

   localparam int NP = 4;
   localparam logic [NP*22-1:0] BASES = {22'h100000, 22'h000000, 22'h000040, 22'h000000};
   localparam logic [NP*22-1:0] MASKS = {22'h3F0000, 22'h3FFF00, 22'h3FFFC0, 22'h3FFFC0};
   localparam logic [21:0] A_UNMAP = 22'h200000;

   logic              HCLK, HRESETn, HREADYS, sel_dec, dft_err_clr;
   logic [21:0]       decode_addr_dec;
   logic [1:0]        trans_dec;
   logic [NP-1:0]     active_in, readyout_in;
   logic [2*NP-1:0]   resp_in;
   logic [32*NP-1:0]  rdata_in, ruser_in;

   logic [NP-1:0] sel_out, sel_out_nh;
   logic          active_dec, active_dec_nh, hready, hready_nh;
   logic [1:0]    hresp, hresp_nh, dstate, dstate_nh;
   logic [31:0]   hrdata, hrdata_nh, hruser, hruser_nh;
   logic [7:0]    ecount, ecount_nh;
   logic [21:0]   eaddr, eaddr_nh;

   int n_checks = 0;
   int n_errors = 0;

   ahb_matrix_decode_multi #(.NUM_PORTS(NP), .PORT_BASE(BASES), .PORT_MASK(MASKS),
                             .CNT_W(8), .IDLE_HOLD(1'b1)) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
      .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .active_in(active_in),
      .readyout_in(readyout_in), .resp_in(resp_in), .rdata_in(rdata_in), .ruser_in(ruser_in),
      .dft_err_clr(dft_err_clr), .sel_out(sel_out), .active_dec(active_dec),
      .HREADYOUTS(hready), .HRESPS(hresp), .HRDATAS(hrdata), .HRUSERS(hruser),
      .dft_err_count(ecount), .dft_err_addr(eaddr), .o_dft_state(dstate));

   ahb_matrix_decode_multi #(.NUM_PORTS(NP), .PORT_BASE(BASES), .PORT_MASK(MASKS),
                             .CNT_W(8), .IDLE_HOLD(1'b0)) u_dut_nh (
      .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
      .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .active_in(active_in),
      .readyout_in(readyout_in), .resp_in(resp_in), .rdata_in(rdata_in), .ruser_in(ruser_in),
      .dft_err_clr(dft_err_clr), .sel_out(sel_out_nh), .active_dec(active_dec_nh),
      .HREADYOUTS(hready_nh), .HRESPS(hresp_nh), .HRDATAS(hrdata_nh), .HRUSERS(hruser_nh),
      .dft_err_count(ecount_nh), .dft_err_addr(eaddr_nh), .o_dft_state(dstate_nh));

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive(input logic sel, input logic [1:0] trans, input logic [21:0] addr,
                        input logic rdy);
      sel_dec         = sel;
      trans_dec       = trans;
      decode_addr_dec = addr;
      HREADYS         = rdy;
      #1;
   endtask

   initial begin
      HRESETn = 1'b1; dft_err_clr = 1'b0;
      sel_dec = 1'b0; trans_dec = 2'b00; decode_addr_dec = '0; HREADYS = 1'b1;
      active_in = 4'b1010; readyout_in = 4'b1111; resp_in = '0;
      for (int i = 0; i < NP; i++) begin
         rdata_in[32*i +: 32] = 32'hA000_0000 + 32'(i);
         ruser_in[32*i +: 32] = 32'hB000_0000 + 32'(i);
      end
      #2 HRESETn = 1'b0;
      #1;
      check_val("rst_hready", 32'(hready), 32'h1);
      check_val("rst_hresp", 32'(hresp), 32'h0);
      check_val("rst_hrdata", hrdata, 32'h0);
      check_val("rst_hruser", hruser, 32'h0);
      check_val("rst_count", 32'(ecount), 32'h0);
      check_val("rst_addr", 32'(eaddr), 32'h0);
      check_val("rst_state", 32'(dstate), 32'h0);
      tick(); tick();
      HRESETn = 1'b1;
      tick();

      // port1 decode and data-phase mux
      drive(1'b1, 2'b10, 22'h000041, 1'b1);
      check_val("dec_p1_sel", 32'(sel_out), 32'h2);
      check_val("dec_p1_act", 32'(active_dec), 32'h1);
      tick();
      check_val("dp_p1_rdata", hrdata, 32'hA000_0001);
      check_val("dp_p1_ruser", hruser, 32'hB000_0001);
      check_val("dp_p1_ready", 32'(hready), 32'h1);
      readyout_in = 4'b1101; resp_in[3:2] = 2'b01;
      #1;
      check_val("dp_p1_wait", 32'(hready), 32'h0);
      check_val("dp_p1_resp", 32'(hresp), 32'h1);
      readyout_in = 4'b1111; resp_in = '0;

      // overlap and other ports
      drive(1'b1, 2'b10, 22'h000010, 1'b1);
      check_val("ovl_p0_sel", 32'(sel_out), 32'h1);
      check_val("ovl_p0_act", 32'(active_dec), 32'h0);
      drive(1'b1, 2'b10, 22'h000080, 1'b1);
      check_val("dec_p2_sel", 32'(sel_out), 32'h4);
      drive(1'b1, 2'b10, 22'h100005, 1'b1);
      check_val("dec_p3_sel", 32'(sel_out), 32'h8);
      drive(1'b0, 2'b10, 22'h100005, 1'b1);
      check_val("nosel", 32'(sel_out), 32'h0);

      // IDLE to unmapped address while data phase is on port1
      drive(1'b1, 2'b10, 22'h000041, 1'b1);
      tick();
      drive(1'b1, 2'b00, A_UNMAP, 1'b1);
      check_val("hold_sel", 32'(sel_out), 32'h2);
      check_val("nohold_sel", 32'(sel_out_nh), 32'h0);
      check_val("nohold_act", 32'(active_dec_nh), 32'h1);
      tick();
      check_val("hold_rdata", hrdata, 32'hA000_0001);
      check_val("hold_count", 32'(ecount), 32'h0);
      check_val("nohold_rdata", hrdata_nh, 32'h0);
      check_val("nohold_ready", 32'(hready_nh), 32'h1);
      check_val("nohold_resp", 32'(hresp_nh), 32'h0);
      check_val("nohold_count", 32'(ecount_nh), 32'h0);

      // single unmapped NONSEQ: two-cycle ERROR
      drive(1'b1, 2'b10, A_UNMAP, 1'b1);
      tick();
      check_val("err1_ready", 32'(hready), 32'h0);
      check_val("err1_resp", 32'(hresp), 32'h1);
      check_val("err1_state", 32'(dstate), 32'h1);
      check_val("err1_count", 32'(ecount), 32'h1);
      check_val("err1_addr", 32'(eaddr), 32'(A_UNMAP));
      drive(1'b1, 2'b00, A_UNMAP, 1'b0);
      tick();
      check_val("err2_ready", 32'(hready), 32'h1);
      check_val("err2_resp", 32'(hresp), 32'h1);
      check_val("err2_state", 32'(dstate), 32'h2);
      drive(1'b0, 2'b00, A_UNMAP, 1'b1);
      tick();
      check_val("err_done_ready", 32'(hready), 32'h1);
      check_val("err_done_resp", 32'(hresp), 32'h0);
      check_val("err_done_count", 32'(ecount), 32'h1);

      // back-to-back errors: ERR2 -> ERR1 with no OKAY cycle
      drive(1'b1, 2'b10, 22'h200001, 1'b1);
      tick();
      check_val("b2b_a_ready", 32'(hready), 32'h0);
      check_val("b2b_a_count", 32'(ecount), 32'h2);
      drive(1'b1, 2'b00, 22'h200001, 1'b0);
      tick();
      check_val("b2b_a2_resp", 32'(hresp), 32'h1);
      drive(1'b1, 2'b11, 22'h200002, 1'b1);
      tick();
      check_val("b2b_b_state", 32'(dstate), 32'h1);
      check_val("b2b_b_ready", 32'(hready), 32'h0);
      check_val("b2b_b_resp", 32'(hresp), 32'h1);
      check_val("b2b_b_count", 32'(ecount), 32'h3);
      check_val("b2b_b_addr", 32'(eaddr), 32'h200002);
      drive(1'b0, 2'b00, A_UNMAP, 1'b0);
      tick();
      drive(1'b0, 2'b00, A_UNMAP, 1'b1);
      tick();
      check_val("b2b_idle_state", 32'(dstate), 32'h0);

      // saturation
      for (int k = 0; k < 300; k++) begin
         drive(1'b1, 2'b10, A_UNMAP + 22'(k), 1'b1);
         tick();
      end
      check_val("sat_count", 32'(ecount), 32'd255);
      check_val("sat_addr", 32'(eaddr), 32'h20012B);
      check_val("sat_count_nh", 32'(ecount_nh), 32'd255);
      drive(1'b1, 2'b10, A_UNMAP, 1'b1);
      tick();
      check_val("sat_hold", 32'(ecount), 32'd255);

      // clear coincident with an event, then clear alone
      dft_err_clr = 1'b1;
      drive(1'b1, 2'b10, 22'h200077, 1'b1);
      tick();
      check_val("clr_evt_count", 32'(ecount), 32'h1);
      check_val("clr_evt_addr", 32'(eaddr), 32'h200077);
      drive(1'b0, 2'b00, A_UNMAP, 1'b1);
      tick();
      check_val("clr_count", 32'(ecount), 32'h0);
      check_val("clr_addr", 32'(eaddr), 32'h0);
      dft_err_clr = 1'b0;
      tick(); tick();

      // reset in the middle of ERR1
      drive(1'b1, 2'b10, A_UNMAP, 1'b1);
      tick();
      check_val("pre_rst_ready", 32'(hready), 32'h0);
      sel_dec = 1'b0;
      HRESETn = 1'b0;
      #1;
      check_val("mid_rst_ready", 32'(hready), 32'h1);
      check_val("mid_rst_resp", 32'(hresp), 32'h0);
      check_val("mid_rst_state", 32'(dstate), 32'h0);
      check_val("mid_rst_count", 32'(ecount), 32'h0);
      tick();
      HRESETn = 1'b1;
      tick();
      check_val("post_rst_rdata", hrdata, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
